// File: rtl/tlb_op_sequencer_if.sv
// Bundle of pipeline, CP0 and TLB-array signals around the TLB operation sequencer.
// master = pipeline/CP0/array side, slave = the sequencer itself.
interface tlb_op_sequencer_if #(
  parameter int IDX_W = 4
) ();
  logic             op_valid_i;
  logic [1:0]       op_i;
  logic             flush_i;
  logic [31:0]      index_i;
  logic [31:0]      random_i;
  logic [31:0]      entryhi_i;
  logic [31:0]      entrylo0_i;
  logic [31:0]      entrylo1_i;
  logic [31:0]      pagemask_i;
  logic [IDX_W-1:0] tlb_addr_o;
  logic             tlb_we_o;
  logic [95:0]      tlb_wdata_o;
  logic [95:0]      tlb_rdata_i;
  logic             stall_o;
  logic             done_o;
  logic             cp0_index_we_o;
  logic [31:0]      cp0_index_o;
  logic             cp0_entry_we_o;
  logic [31:0]      cp0_entryhi_o;
  logic [31:0]      cp0_entrylo0_o;
  logic [31:0]      cp0_entrylo1_o;
  logic [31:0]      cp0_pagemask_o;

  modport master (
    output op_valid_i, op_i, flush_i, index_i, random_i, entryhi_i,
           entrylo0_i, entrylo1_i, pagemask_i, tlb_rdata_i,
    input  tlb_addr_o, tlb_we_o, tlb_wdata_o, stall_o, done_o,
           cp0_index_we_o, cp0_index_o, cp0_entry_we_o, cp0_entryhi_o,
           cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o
  );

  modport slave (
    input  op_valid_i, op_i, flush_i, index_i, random_i, entryhi_i,
           entrylo0_i, entrylo1_i, pagemask_i, tlb_rdata_i,
    output tlb_addr_o, tlb_we_o, tlb_wdata_o, stall_o, done_o,
           cp0_index_we_o, cp0_index_o, cp0_entry_we_o, cp0_entryhi_o,
           cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o
  );
endinterface

// File: rtl/tlb_op_sequencer.sv
// Multi-cycle sequencer for MIPS TLBP/TLBR/TLBWI/TLBWR over a single-port
// synchronous TLB array; stalls the pipeline and writes results back to CP0.
module tlb_op_sequencer #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  tlb_op_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_READ_WB, S_PROBE, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR
  } op_t;

  localparam logic [IDX_W:0] CNT_END = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  state_t           state, state_nxt;
  logic [IDX_W:0]   cnt, cnt_nxt;
  logic             accept;

  logic [18:0]      vpn2_q;
  logic [7:0]       asid_q;
  logic [15:0]      mask_q;
  logic [25:0]      lo0_q;
  logic [25:0]      lo1_q;
  logic [IDX_W-1:0] tgt_q;
  logic [3:0]       idx4_q;

  logic [IDX_W-1:0] addr_c;
  logic             we_c;
  logic [95:0]      wdata_c;
  logic             done_c;
  logic             stall_c;
  logic             index_we_c;
  logic [31:0]      index_c;
  logic             entry_we_c;
  logic [31:0]      entryhi_c, entrylo0_c, entrylo1_c, pagemask_c;
  logic [IDX_W:0]   prev_cnt;

  // Packed entry: {2'b0, VPN2[18:0], ASID[7:0], MASK[15:0], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1}
  function automatic logic [95:0] pack_entry(
    input logic [18:0] vpn2, input logic [7:0] asid, input logic [15:0] mask,
    input logic [25:0] lo0, input logic [25:0] lo1
  );
    return {2'b00, vpn2, asid, mask, lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
  endfunction

  function automatic logic entry_match(
    input logic [95:0] e, input logic [18:0] vpn2, input logic [7:0] asid
  );
    logic [18:0] keep;
    keep = ~{3'b000, e[66:51]};
    return ((e[93:75] & keep) == (vpn2 & keep)) && (e[50] || (e[74:67] == asid));
  endfunction

  assign accept   = (state == S_IDLE) && bus.op_valid_i && !bus.flush_i && !rst;
  assign prev_cnt = cnt - CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand capture at accept; data path carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      vpn2_q <= bus.entryhi_i[31:13];
      asid_q <= bus.entryhi_i[7:0];
      mask_q <= bus.pagemask_i[28:13];
      lo0_q  <= bus.entrylo0_i[25:0];
      lo1_q  <= bus.entrylo1_i[25:0];
      idx4_q <= bus.index_i[3:0];
      tgt_q  <= (bus.op_i == OP_TLBWR) ? bus.random_i[IDX_W-1:0]
                                       : bus.index_i[IDX_W-1:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_c     = '0;
    we_c       = 1'b0;
    wdata_c    = '0;
    done_c     = 1'b0;
    index_we_c = 1'b0;
    index_c    = '0;
    entry_we_c = 1'b0;
    entryhi_c  = '0;
    entrylo0_c = '0;
    entrylo1_c = '0;
    pagemask_c = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.op_valid_i) begin
          unique case (bus.op_i)
            OP_TLBP: begin
              state_nxt = S_PROBE;
              cnt_nxt   = '0;
            end
            OP_TLBR: state_nxt = S_READ;
            default: state_nxt = S_WRITE;
          endcase
        end
      end
      S_WRITE: begin
        we_c      = 1'b1;
        addr_c    = tgt_q;
        wdata_c   = pack_entry(vpn2_q, asid_q, mask_q, lo0_q, lo1_q);
        state_nxt = S_DONE;
      end
      S_READ: begin
        addr_c    = tgt_q;
        state_nxt = S_READ_WB;
      end
      S_READ_WB: begin
        entry_we_c = 1'b1;
        entryhi_c  = {bus.tlb_rdata_i[93:75], 5'b0, bus.tlb_rdata_i[74:67]};
        entrylo0_c = {6'b0, bus.tlb_rdata_i[49:25], bus.tlb_rdata_i[50]};
        entrylo1_c = {6'b0, bus.tlb_rdata_i[24:0], bus.tlb_rdata_i[50]};
        pagemask_c = {3'b0, bus.tlb_rdata_i[66:51], 13'b0};
        state_nxt  = S_DONE;
      end
      S_PROBE: begin
        // Address c is issued while the entry for c-1 comes back from the array
        if (cnt < CNT_END) addr_c = cnt[IDX_W-1:0];
        cnt_nxt = cnt + CNT_ONE;
        if ((cnt != '0) && entry_match(bus.tlb_rdata_i, vpn2_q, asid_q)) begin
          index_we_c = 1'b1;
          index_c    = {{(32-IDX_W){1'b0}}, prev_cnt[IDX_W-1:0]};
          state_nxt  = S_DONE;
        end else if (cnt == CNT_END) begin
          index_we_c = 1'b1;
          index_c    = {1'b1, 27'b0, idx4_q};
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    stall_c = ((state != S_IDLE) && (state != S_DONE)) ||
              ((state == S_IDLE) && bus.op_valid_i);
  end

  // Strobes are suppressed by flush or reset; everything is zero under reset
  assign bus.tlb_addr_o     = rst ? '0 : addr_c;
  assign bus.tlb_we_o       = we_c & ~rst & ~bus.flush_i;
  assign bus.tlb_wdata_o    = rst ? '0 : wdata_c;
  assign bus.stall_o        = stall_c & ~rst;
  assign bus.done_o         = done_c & ~rst & ~bus.flush_i;
  assign bus.cp0_index_we_o = index_we_c & ~rst & ~bus.flush_i;
  assign bus.cp0_index_o    = rst ? '0 : index_c;
  assign bus.cp0_entry_we_o = entry_we_c & ~rst & ~bus.flush_i;
  assign bus.cp0_entryhi_o  = rst ? '0 : entryhi_c;
  assign bus.cp0_entrylo0_o = rst ? '0 : entrylo0_c;
  assign bus.cp0_entrylo1_o = rst ? '0 : entrylo1_c;
  assign bus.cp0_pagemask_o = rst ? '0 : pagemask_c;

  logic unused_bits;
  assign unused_bits = ^{bus.index_i[31:4], bus.random_i[31:IDX_W], bus.entryhi_i[12:8],
                         bus.entrylo0_i[31:26], bus.entrylo1_i[31:26],
                         bus.pagemask_i[31:29], bus.pagemask_i[12:0],
                         bus.tlb_rdata_i[95:94], prev_cnt[IDX_W]};

endmodule
